// File: rtl/viterbi_dec_k5.sv
// ---------------------------------------------------------------------------
// viterbi_dec_k5
//
// Hard-decision Viterbi decoder for the rate-1/2, K=5 convolutional code
// with generators g0 = 5'b11101 and g1 = 5'b10011. It has 16 trellis states,
// a full add-compare-select every accepted symbol, and register-exchange
// survivor memory TB_DEPTH bits deep. It emits one decoded info bit per
// accepted symbol, TB_DEPTH symbols after that bit entered the trellis.
//
// Trellis state s[3:0] holds the four previous info bits, with s[3] the
// oldest. Info bit u moves the trellis to {s[2:0],u} and produces
//    c0 = s[3]^s[2]^s[1]^u,   c1 = s[3]^s[0]^u.
//
// Parameters
//   TB_DEPTH : survivor length and decode latency in symbols (8..64)
//   PM_W     : path-metric width in bits (>= 6)
//
// Ports
//   clk       in   clock, rising edge active
//   rst       in   asynchronous active-high reset
//   clr       in   synchronous trellis restart, overrides in_valid
//   in_valid  in   code_in carries a symbol this cycle
//   code_in   in   [0] = g0 parity, [1] = g1 parity
//   best_pm   out  best normalized path metric (VITERBI_PM_OUT_EN only)
//   out_valid out  data_out holds a decoded bit this cycle
//   data_out  out  decoded info bit
//
// Optional feature macro: VITERBI_PM_OUT_EN adds the best_pm output.
// ---------------------------------------------------------------------------
module viterbi_dec_k5 #(
   parameter int TB_DEPTH = 24,
   parameter int PM_W     = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            in_valid,
   input  logic [1:0]      code_in,
`ifdef VITERBI_PM_OUT_EN
   output logic [PM_W-1:0] best_pm,
`endif
   output logic            out_valid,
   output logic            data_out
);

   localparam int NS    = 16;
   localparam int CNT_W = $clog2(TB_DEPTH + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB_DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
   // Non-zero start states carry a handicap, so decoding begins from state 0.
   localparam logic [PM_W-1:0]  PM_START = PM_W'(16);

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------
   // Predecessor of next state n whose oldest bit was b.
   function automatic logic [3:0] pred(input logic [3:0] n, input logic b);
      return {b, n[3:1]};
   endfunction

   // Hamming distance between the received symbol and the symbol that the
   // branch leaving state s on input u would have produced.
   function automatic logic [1:0] branch_metric(input logic [3:0] s,
                                                input logic       u,
                                                input logic [1:0] sym);
      logic c0;
      logic c1;
      c0 = s[3] ^ s[2] ^ s[1] ^ u;
      c1 = s[3] ^ s[0] ^ u;
      return {1'b0, c0 ^ sym[0]} + {1'b0, c1 ^ sym[1]};
   endfunction

   // Subtract half the metric range from every state at once. This is only
   // applied when all metrics are in the upper half, so no metric goes
   // negative and the relative order of states is unchanged.
   function automatic logic [PM_W-1:0] normalize(input logic [PM_W-1:0] pm,
                                                 input logic            en);
      return en ? {1'b0, pm[PM_W-2:0]} : pm;
   endfunction

   function automatic logic [PM_W-1:0] pm_init(input int s);
      return (s == 0) ? '0 : PM_START;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PM_W-1:0]     pm_q      [NS];
   logic [PM_W-1:0]     pm_d      [NS];
   logic [TB_DEPTH-1:0] surv_q    [NS];
   logic [TB_DEPTH-1:0] surv_d    [NS];
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                data_q,      data_d;
`ifdef VITERBI_PM_OUT_EN
   logic [PM_W-1:0]     best_pm_q,   best_pm_d;
`endif

   // ------------------------------------------------------------------------
   // Add-compare-select
   // ------------------------------------------------------------------------
   logic [PM_W-1:0]     acs_pm    [NS];
   logic [3:0]          acs_from  [NS];
   logic                all_msb;
   logic [PM_W-1:0]     cand0;
   logic [PM_W-1:0]     cand1;
   logic [3:0]          p0;
   logic [3:0]          p1;

   always_comb begin
      all_msb = 1'b1;
      cand0   = '0;
      cand1   = '0;
      p0      = '0;
      p1      = '0;
      for (int n = 0; n < NS; n++) begin
         p0    = pred(4'(n), 1'b0);
         p1    = pred(4'(n), 1'b1);
         cand0 = pm_q[p0] + PM_W'(branch_metric(p0, n[0], code_in));
         cand1 = pm_q[p1] + PM_W'(branch_metric(p1, n[0], code_in));
         // Strict compare so that p0 keeps the path on a tie.
         acs_pm[n]   = cand0;
         acs_from[n] = p0;
         if (cand1 < cand0) begin
            acs_pm[n]   = cand1;
            acs_from[n] = p1;
         end
         all_msb = all_msb & acs_pm[n][PM_W-1];
      end
   end

   // ------------------------------------------------------------------------
   // Normalization, survivor exchange and best-state search
   // ------------------------------------------------------------------------
   logic [PM_W-1:0]     norm_pm   [NS];
   logic [TB_DEPTH-1:0] new_surv  [NS];
   logic [3:0]          best_idx;
   logic [PM_W-1:0]     best_val;

   always_comb begin
      best_idx = '0;
      best_val = '0;
      for (int n = 0; n < NS; n++) begin
         norm_pm[n]  = normalize(acs_pm[n], all_msb);
         // Each survivor inherits its winner's history and appends its own
         // decision bit, which is the newest info bit n[0].
         new_surv[n] = {surv_q[acs_from[n]][TB_DEPTH-2:0], n[0]};
      end
      // Strict compare so that the lowest index wins a tie.
      best_val = norm_pm[0];
      for (int n = 1; n < NS; n++) begin
         if (norm_pm[n] < best_val) begin
            best_val = norm_pm[n];
            best_idx = 4'(n);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state selection
   // ------------------------------------------------------------------------
   always_comb begin
      for (int s = 0; s < NS; s++) begin
         pm_d[s]   = pm_q[s];
         surv_d[s] = surv_q[s];
      end
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      data_d      = data_q;
`ifdef VITERBI_PM_OUT_EN
      best_pm_d   = best_pm_q;
`endif
      if (clr) begin
         // Restart the trellis. The symbol presented with clr is discarded.
         for (int s = 0; s < NS; s++) begin
            pm_d[s]   = pm_init(s);
            surv_d[s] = '0;
         end
         cnt_d  = '0;
         data_d = 1'b0;
`ifdef VITERBI_PM_OUT_EN
         best_pm_d = '0;
`endif
      end else if (in_valid) begin
         for (int s = 0; s < NS; s++) begin
            pm_d[s]   = norm_pm[s];
            surv_d[s] = new_surv[s];
         end
         cnt_d       = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
         // cnt_q counts the symbols accepted before this one.
         out_valid_d = (cnt_q >= CNT_LAST);
         data_d      = new_surv[best_idx][TB_DEPTH-1];
`ifdef VITERBI_PM_OUT_EN
         best_pm_d   = best_val;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NS; s++) begin
            pm_q[s]   <= pm_init(s);
            surv_q[s] <= '0;
         end
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         data_q      <= 1'b0;
`ifdef VITERBI_PM_OUT_EN
         best_pm_q   <= '0;
`endif
      end else begin
         for (int s = 0; s < NS; s++) begin
            pm_q[s]   <= pm_d[s];
            surv_q[s] <= surv_d[s];
         end
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
`ifdef VITERBI_PM_OUT_EN
         best_pm_q   <= best_pm_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign data_out  = data_q;
`ifdef VITERBI_PM_OUT_EN
   assign best_pm   = best_pm_q;
`endif

endmodule

// File: tb/tb_viterbi_dec_k5.sv
// ---------------------------------------------------------------------------
// tb_viterbi_dec_k5
//
// Directed bench for viterbi_dec_k5. It contains a K=5 reference encoder,
// a queue holding the info bits each output must reproduce, a vector table
// for the impulse, gap and clr sequence, and hand-written sequences for the
// remaining corner cases.
// ---------------------------------------------------------------------------
module tb_viterbi_dec_k5;

   localparam int TB_DEPTH = 24;
   localparam int PM_W     = 6;

   logic            clk;
   logic            rst;
   logic            clr;
   logic            in_valid;
   logic [1:0]      code_in;
   logic            out_valid;
   logic            data_out;
`ifdef VITERBI_PM_OUT_EN
   logic [PM_W-1:0] best_pm;
`endif

   viterbi_dec_k5 #(
      .TB_DEPTH (TB_DEPTH),
      .PM_W     (PM_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .code_in   (code_in),
`ifdef VITERBI_PM_OUT_EN
      .best_pm   (best_pm),
`endif
      .out_valid (out_valid),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       c;
      logic [1:0] sym;
      logic       ev;
      logic       ed;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] enc_st   = 4'd0;
   logic       exp_q [$];
   logic       last_exp = 1'b0;
   int         acc_cnt  = 0;
   int         out_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] enc_sym(input logic [3:0] s, input logic u);
      return {s[3] ^ s[0] ^ u, s[3] ^ s[2] ^ s[1] ^ u};
   endfunction

   // Inputs change on the falling edge; outputs are sampled on the next
   // falling edge, after the rising edge that consumed the inputs.
   task automatic step(input logic v, input logic c, input logic [1:0] sym);
      in_valid = v;
      clr      = c;
      code_in  = sym;
      @(posedge clk);
      @(negedge clk);
      if (c) acc_cnt = 0;
      else if (v) acc_cnt++;
   endtask

   task automatic collect(input string name);
      logic e;
      if (out_valid === 1'b1) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got an output with no pending info bit (output %0d)",
                     name, out_cnt);
         end else begin
            e        = exp_q.pop_front();
            last_exp = e;
            check(name, data_out, e);
         end
      end
   endtask

   task automatic send_bit(input logic u, input logic [1:0] flip,
                           input string name);
      logic [1:0] s;
      s      = enc_sym(enc_st, u) ^ flip;
      enc_st = {enc_st[2:0], u};
      exp_q.push_back(u);
      step(1'b1, 1'b0, s);
      collect(name);
   endtask

   task automatic restart();
      step(1'b1, 1'b1, 2'b11);
      check("clr_out_valid", out_valid, 0);
      check("clr_data_out", data_out, 0);
      enc_st   = 4'd0;
      exp_q.delete();
      out_cnt  = 0;
      last_exp = 1'b0;
   endtask

   task automatic check_spread();
      int mn;
      int mx;
      mn = 1 << 30;
      mx = -1;
      for (int k = 0; k < 16; k++) begin
         if (int'(dut.pm_q[k]) < mn) mn = int'(dut.pm_q[k]);
         if (int'(dut.pm_q[k]) > mx) mx = int'(dut.pm_q[k]);
      end
      n_checks++;
      if (mx - mn > 8) begin
         n_fail++;
         $display("FAIL pm_spread: got %0d (min %0d max %0d), expected at most 8",
                  mx - mn, mn, mx);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [32];
      logic [1:0] imp [5];
      logic       u;
      logic [1:0] fl;

      rst      = 1'b1;
      clr      = 1'b0;
      in_valid = 1'b0;
      code_in  = 2'b00;

      // Impulse: info 1 then zeros. Only the first decoded bit is 1. The
      // table ends with a gap, in which data_out holds and out_valid drops,
      // and then a clr whose symbol is discarded.
      imp = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b11};
      for (int i = 0; i < 30; i++) begin
         tbl[i].v   = 1'b1;
         tbl[i].c   = 1'b0;
         tbl[i].sym = (i < 5) ? imp[i] : 2'b00;
         tbl[i].ev  = (i >= TB_DEPTH - 1);
         tbl[i].ed  = (i == TB_DEPTH - 1);
      end
      tbl[30] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      tbl[31] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
`ifdef VITERBI_PM_OUT_EN
      check("rst_best_pm", best_pm, 0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         step(tbl[i].v, tbl[i].c, tbl[i].sym);
         check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
         if (tbl[i].ev || !tbl[i].v || tbl[i].c)
            check($sformatf("tbl%0d_data_out", i), data_out, tbl[i].ed);
      end
      enc_st   = 4'd0;
      exp_q.delete();
      out_cnt  = 0;
      last_exp = 1'b0;

      // All-zero stream, starting right after the table's clr
      for (int i = 0; i < 100; i++) begin
         send_bit(1'b0, 2'b00, "zero_data");
         check("zero_out_valid", out_valid, (i >= TB_DEPTH - 1));
`ifdef VITERBI_PM_OUT_EN
         check("zero_best_pm", best_pm, 0);
`endif
      end

      // Error correction: single flipped bits in symbols 10, 40 and 90
      restart();
      for (int i = 0; i < 200 + TB_DEPTH; i++) begin
         u  = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
         fl = (i == 9) ? 2'b01 : (i == 39) ? 2'b10 : (i == 89) ? 2'b01 : 2'b00;
         send_bit(u, fl, "ecc_data");
      end
      check("ecc_out_count", out_cnt, 200 + 1);

      // 3-cycle gaps every 5 symbols
      restart();
      for (int i = 0; i < 80; i++) begin
         send_bit(1'($urandom_range(0, 1)), 2'b00, "gap_data");
         if (i % 5 == 4) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
               check("gap_out_valid", out_valid, 0);
               check("gap_data_hold", data_out, last_exp);
            end
         end
      end
      check("gap_out_count", out_cnt, 80 - TB_DEPTH + 1);

      // clr presented with symbol 50
      restart();
      for (int i = 0; i < 49; i++)
         send_bit(1'($urandom_range(0, 1)), 2'b00, "pre_clr_data");
      check("pre_clr_out_count", out_cnt, 49 - TB_DEPTH + 1);
      restart();
      for (int i = 0; i < 34; i++) begin
         send_bit(1'($urandom_range(0, 1)), 2'b00, "post_clr_data");
         check("post_clr_out_valid", out_valid, (i >= TB_DEPTH - 1));
      end

      // Asynchronous reset between edges after symbol 70. The output then
      // shown belongs to symbol 47, which is forced to 1 so that the drop
      // of data_out is visible.
      restart();
      for (int i = 0; i < 70; i++) begin
         u = (i == 46) ? 1'b1 : 1'($urandom_range(0, 1));
         send_bit(u, 2'b00, "pre_rst_data");
      end
      check("pre_rst_out_valid", out_valid, 1);
      check("pre_rst_data_out", data_out, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_data_out", data_out, 0);
`ifdef VITERBI_PM_OUT_EN
      check("arst_best_pm", best_pm, 0);
`endif
      in_valid = 1'b0;
      @(negedge clk);
      rst      = 1'b0;
      enc_st   = 4'd0;
      exp_q.delete();
      out_cnt  = 0;
      last_exp = 1'b0;
      acc_cnt  = 0;
      for (int i = 0; i < 40; i++) begin
         send_bit(1'($urandom_range(0, 1)), 2'b00, "post_rst_data");
         check("post_rst_out_valid", out_valid, (i >= TB_DEPTH - 1));
      end

      // Long run, one flipped bit every 8 symbols, to exercise normalization
      restart();
      for (int i = 0; i < 5000; i++) begin
         fl = (i % 8 == 5) ? (((i / 8) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         send_bit(1'($urandom_range(0, 1)), fl, "long_data");
         if (acc_cnt >= 4) check_spread();
      end
      check("long_out_count", out_cnt, 5000 - TB_DEPTH + 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
